// File: rtl/progpow_search_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : progpow_search_pkg
//  Brief   : Shared types and helper functions for the ProgPoW nonce search.
//  Rev     : 1.0  initial release
// ============================================================================
package progpow_search_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } search_state_e;

    typedef logic [7:0][31:0] hash_words_t;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Big-endian 64-bit value taken from the first two squeezed words
    function automatic logic [63:0] hash_value(input hash_words_t hw);
        return {bswap32(hw[0]), bswap32(hw[1])};
    endfunction

endpackage
`default_nettype wire

// File: rtl/progpow_target_cmp.sv
`default_nettype none
// ============================================================================
//  Module  : progpow_target_cmp
//  Brief   : Forms the 64-bit hash value and compares it against the target.
//  Rev     : 1.0  initial release
// ============================================================================
module progpow_target_cmp
    import progpow_search_pkg::*;
(
    input  hash_words_t hash_words,
    input  logic [63:0] target,
    output logic [63:0] hv,
    output logic        win
);

    logic [191:0] w_unused_words;

    assign hv             = hash_value(hash_words);
    assign win            = (hv <= target);
    assign w_unused_words = hash_words[7:2];

endmodule
`default_nettype wire

// File: rtl/progpow_nonce_search.sv
`default_nettype none
// ============================================================================
//  Module  : progpow_nonce_search
//  Brief   : Nonce-search controller around the keccak_f800 hash stage.
//            Optional PROGPOW_SEARCH_RSPCHK_EN adds in-order nonce checking.
//  Rev     : 1.0  initial release
// ============================================================================
module progpow_nonce_search
    import progpow_search_pkg::*;
#(
    parameter int MAX_OUT = 4,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [63:0]       start_nonce,
    input  logic [CNT_W-1:0]  nonce_count,
    input  logic [63:0]       target,
    input  logic              abort,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [63:0]       req_nonce,
    input  logic              rsp_valid,
    input  logic [63:0]       rsp_nonce,
    input  logic [255:0]      rsp_hash,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [63:0]       found_nonce,
    output logic [63:0]       found_hash,
    output logic [CNT_W-1:0]  hashes_done
`ifdef PROGPOW_SEARCH_RSPCHK_EN
    ,
    output logic              rsp_err
`endif
);

    localparam int                 c_out_w   = $clog2(MAX_OUT + 1);
    localparam logic [c_out_w-1:0] c_max_out = c_out_w'(MAX_OUT);
    localparam logic [c_out_w-1:0] c_out_one = c_out_w'(1);
    localparam logic [CNT_W-1:0]   c_cnt_one = CNT_W'(1);

    search_state_e      r_state;
    search_state_e      w_state_nxt;
    logic [63:0]        r_start_nonce;
    logic [63:0]        r_nonce;
    logic [CNT_W-1:0]   r_nonce_count;
    logic [CNT_W-1:0]   r_issued;
    logic [CNT_W-1:0]   r_hashes_done;
    logic [63:0]        r_target;
    logic [c_out_w-1:0] r_outstanding;
    logic               r_found;
    logic [63:0]        r_found_nonce;
    logic [63:0]        r_found_hash;

    hash_words_t        w_hash_words;
    logic [63:0]        w_hv;
    logic               w_win;
    logic               w_start;
    logic               w_req_fire;
    logic               w_rsp_take;
    logic               w_capture;
    logic [63:0]        w_exp_nonce;

    assign w_hash_words = rsp_hash;

    progpow_target_cmp u_target_cmp (
        .hash_words (w_hash_words),
        .target     (r_target),
        .hv         (w_hv),
        .win        (w_win)
    );

    // Responses with nothing outstanding (e.g. stragglers after reset) are dropped
    assign w_start     = (r_state == IDLE) && start;
    assign w_req_fire  = req_valid && req_ready;
    assign w_rsp_take  = rsp_valid && (r_outstanding != '0);
    assign w_capture   = w_rsp_take && w_win && !r_found;
    assign w_exp_nonce = r_start_nonce + 64'(r_hashes_done);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_start_nonce <= '0;
            r_nonce       <= '0;
            r_nonce_count <= '0;
            r_issued      <= '0;
            r_hashes_done <= '0;
            r_target      <= '0;
            r_outstanding <= '0;
            r_found       <= 1'b0;
            r_found_nonce <= '0;
            r_found_hash  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_start_nonce <= start_nonce;
                r_nonce       <= start_nonce;
                r_nonce_count <= nonce_count;
                r_target      <= target;
                r_issued      <= '0;
                r_hashes_done <= '0;
                r_found       <= 1'b0;
                r_found_nonce <= '0;
                r_found_hash  <= '0;
            end else begin
                if (w_req_fire) begin
                    r_nonce  <= r_nonce + 64'd1;
                    r_issued <= r_issued + c_cnt_one;
                end
                if (w_rsp_take) begin
                    r_hashes_done <= r_hashes_done + c_cnt_one;
                end
                if (w_capture) begin
                    r_found       <= 1'b1;
                    r_found_nonce <= w_exp_nonce;
                    r_found_hash  <= w_hv;
                end
            end
            case ({w_req_fire, w_rsp_take})
                2'b10:   r_outstanding <= r_outstanding + c_out_one;
                2'b01:   r_outstanding <= r_outstanding - c_out_one;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Issue is suppressed in the cycle a winner or abort arrives so no extra
    // request slips out behind the stop condition.
    always_comb begin
        w_state_nxt = r_state;
        req_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = RUN;
            end
            RUN: begin
                req_valid = (r_issued < r_nonce_count) && (r_outstanding < c_max_out)
                            && !abort && !w_capture;
                if ((r_issued == r_nonce_count) || w_capture || abort) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (r_outstanding == '0) w_state_nxt = DONE;
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign req_nonce   = r_nonce;
    assign busy        = (r_state == RUN) || (r_state == DRAIN);
    assign done        = (r_state == DONE);
    assign found       = r_found;
    assign found_nonce = r_found_nonce;
    assign found_hash  = r_found_hash;
    assign hashes_done = r_hashes_done;

`ifdef PROGPOW_SEARCH_RSPCHK_EN
    logic r_rsp_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_err <= 1'b0;
        end else if (w_start) begin
            r_rsp_err <= 1'b0;
        end else if (w_rsp_take && (rsp_nonce != w_exp_nonce)) begin
            r_rsp_err <= 1'b1;
        end
    end

    assign rsp_err = r_rsp_err;
`else
    logic w_unused_rsp_nonce;
    assign w_unused_rsp_nonce = ^rsp_nonce;
`endif

endmodule
`default_nettype wire

// File: tb/tb_progpow_nonce_search.sv
`default_nettype none
// ============================================================================
//  Module  : tb_progpow_nonce_search
//  Brief   : Randomized bench with a queue-based hasher and reference model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_progpow_nonce_search;

    localparam int c_max_out = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [63:0]  start_nonce = '0;
    logic [31:0]  nonce_count = '0;
    logic [63:0]  target = '0;
    logic         abort = 1'b0;
    logic         req_valid;
    logic         req_ready = 1'b0;
    logic [63:0]  req_nonce;
    logic         rsp_valid = 1'b0;
    logic [63:0]  rsp_nonce = '0;
    logic [255:0] rsp_hash = '0;
    logic         busy, done, found;
    logic [63:0]  found_nonce, found_hash;
    logic [31:0]  hashes_done;
`ifdef PROGPOW_SEARCH_RSPCHK_EN
    logic         rsp_err;
`endif

    progpow_nonce_search #(.MAX_OUT(c_max_out), .CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .start_nonce (start_nonce),
        .nonce_count (nonce_count),
        .target      (target),
        .abort       (abort),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_nonce   (req_nonce),
        .rsp_valid   (rsp_valid),
        .rsp_nonce   (rsp_nonce),
        .rsp_hash    (rsp_hash),
        .busy        (busy),
        .done        (done),
        .found       (found),
        .found_nonce (found_nonce),
        .found_hash  (found_hash),
        .hashes_done (hashes_done)
`ifdef PROGPOW_SEARCH_RSPCHK_EN
        ,
        .rsp_err     (rsp_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]  nonce;
        logic [255:0] hash;
        int           due;
    } req_t;

    req_t        q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc, abort_at, stall_until, ready_pct, lat_lo, lat_hi, hash_mode, corrupt_idx;
    int          n_hs, n_rsp, n_done, done_cyc, max_out, win_cyc, stop_cyc;
    logic        rst_drv = 1'b1;
    logic        start_en = 1'b0;
    logic        hold_pend;
    logic [63:0] hold_nonce, exp_req, m_target, m_fn, m_fh;
    logic        m_found;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [63:0] ref_hv(input logic [255:0] h);
        logic [31:0] w0, w1, r0, r1;
        w0 = h[31:0];
        w1 = h[63:32];
        r0 = {<<8{w0}};
        r1 = {<<8{w1}};
        return {r0, r1};
    endfunction

    function automatic logic [255:0] gen_hash(input int mode);
        logic [255:0] h;
        for (int i = 0; i < 8; i++) h[32*i +: 32] = $urandom;
        if (mode == 0) h[0] = 1'b1;
        if (mode == 2) h[63:0] = 64'h0000_0000_0000_0001;
        return h;
    endfunction

    // One clock: drive at negedge, observe just before the next posedge
    task automatic tick();
        req_t ent;
        logic [63:0] hv;
        @(negedge clk);
        rst       = rst_drv;
        start     = start_en && (cyc == 0);
        abort     = (cyc == abort_at);
        req_ready = (cyc >= stall_until) && ($urandom_range(0, 99) < ready_pct);
        if (q.size() != 0 && q[0].due <= cyc) begin
            rsp_valid = 1'b1;
            rsp_hash  = q[0].hash;
            rsp_nonce = (n_rsp == corrupt_idx) ? ~q[0].nonce : q[0].nonce;
        end else begin
            rsp_valid = 1'b0;
            rsp_hash  = {8{$urandom}};
            rsp_nonce = '0;
        end
        #4;
        if (hold_pend && req_valid) chk("req_hold", req_nonce, hold_nonce);
        hold_pend  = req_valid && !req_ready;
        hold_nonce = req_nonce;
        if (m_found && cyc == win_cyc + 1) chk("found_lat", found, 1);
        if (abort && cyc < stop_cyc) stop_cyc = cyc;
        if (req_valid && req_ready) begin
            chk("req_nonce", req_nonce, exp_req);
            chk("issue_after_stop", cyc > stop_cyc, 0);
            ent.nonce = exp_req;
            ent.hash  = gen_hash(hash_mode);
            ent.due   = cyc + $urandom_range(lat_lo, lat_hi);
            q.push_back(ent);
            exp_req = exp_req + 64'd1;
            n_hs++;
        end
        if (rsp_valid) begin
            ent = q.pop_front();
            n_rsp++;
            hv = ref_hv(ent.hash);
            if (!m_found && hv <= m_target) begin
                chk("found_pre", found, 0);
                m_found = 1'b1;
                m_fn    = ent.nonce;
                m_fh    = hv;
                win_cyc = cyc;
                if (cyc < stop_cyc) stop_cyc = cyc;
            end
        end
        if (q.size() > max_out) max_out = q.size();
        if (done) begin
            n_done++;
            if (n_done == 1) done_cyc = cyc;
        end
        cyc++;
    endtask

    task automatic setup_search(input logic [63:0] sn, input logic [31:0] cnt, input logic [63:0] tgt,
                                input int ab, input int mode, input int llo, input int lhi,
                                input int rpct, input int stl, input int cidx);
        start_nonce = sn;
        nonce_count = cnt;
        target      = tgt;
        m_target    = tgt;
        exp_req     = sn;
        abort_at    = ab;
        hash_mode   = mode;
        lat_lo      = llo;
        lat_hi      = lhi;
        ready_pct   = rpct;
        stall_until = stl;
        corrupt_idx = cidx;
        cyc = 0; n_hs = 0; n_rsp = 0; n_done = 0; done_cyc = -1; max_out = 0;
        m_found = 1'b0; m_fn = '0; m_fh = '0; win_cyc = -10; stop_cyc = 1 << 30;
        hold_pend = 1'b0;
        start_en  = 1'b1;
        q.delete();
    endtask

    task automatic run_search(input logic [63:0] sn, input logic [31:0] cnt, input logic [63:0] tgt,
                              input int ab, input int mode, input int llo, input int lhi,
                              input int rpct, input int stl, input int cidx);
        setup_search(sn, cnt, tgt, ab, mode, llo, lhi, rpct, stl, cidx);
        while (n_done == 0 && cyc < 3000) tick();
        repeat (3) tick();
        start_en = 1'b0;
        chk("done_pulses", n_done, 1);
        chk("drained", q.size(), 0);
        chk("hashes_done", hashes_done, n_rsp);
        chk("found", found, m_found);
        chk("found_nonce", found_nonce, m_fn);
        chk("found_hash", found_hash, m_fh);
        chk("busy_end", busy, 0);
        chk("max_out_ok", max_out <= c_max_out, 1);
        if (ab < 0 && !m_found) chk("issued", n_hs, cnt);
`ifdef PROGPOW_SEARCH_RSPCHK_EN
        chk("rsp_err", rsp_err, (cidx >= 0) && (cidx < n_rsp));
`endif
    endtask

    initial begin
        setup_search(0, 0, 0, -1, 0, 1, 1, 0, 0, -1);
        start_en = 1'b0;
        rst_drv  = 1'b1;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_found", found, 0);
        chk("rst_found_nonce", found_nonce, 0);
        chk("rst_found_hash", found_hash, 0);
        chk("rst_hashes", hashes_done, 0);
        chk("rst_req_valid", req_valid, 0);
        chk("rst_req_nonce", req_nonce, 0);
        rst_drv = 1'b0;
        repeat (2) tick();

        // Plain run, no winner
        run_search(64'd0, 5, 64'd0, -1, 0, 1, 3, 100, 0, -1);
        chk("t1_count", n_hs, 5);

        // Everything wins: first nonce captured, issue stops quickly
        begin
            logic [63:0] sn;
            sn = {$urandom, $urandom};
            run_search(sn, 10, 64'hFFFF_FFFF_FFFF_FFFF, -1, 0, 2, 5, 100, 0, -1);
            chk("t2_nonce", found_nonce, sn);
            chk("t2_bound", hashes_done <= c_max_out, 1);
        end

        // Nonce wrap
        run_search(64'hFFFF_FFFF_FFFF_FFFE, 4, 64'd0, -1, 0, 1, 2, 100, 0, -1);

        // Stalled hasher and slow responses
        run_search(64'h55, 12, 64'd0, -1, 0, 8, 15, 100, 20, -1);
        chk("t4_hit_max", max_out, c_max_out);

        // Abort with two in flight
        run_search(64'h1000, 10, 64'd0, 3, 0, 10, 12, 100, 0, -1);
        chk("t5_abort_hd", hashes_done, 2);

        // Zero-length search
        run_search(64'h77, 0, 64'd0, -1, 0, 1, 2, 100, 0, -1);
        chk("t5_zero_done_cyc", done_cyc, 3);
        chk("t5_zero_reqs", n_hs, 0);

        // Exact boundary of the compare
        run_search(64'h200, 3, 64'h0100_0000_0000_0000, -1, 2, 1, 3, 100, 0, -1);
        chk("t6_hv", found_hash, 64'h0100_0000_0000_0000);
        run_search(64'h300, 3, 64'h00FF_FFFF_FFFF_FFFF, -1, 2, 1, 3, 100, 0, -1);
        chk("t6_below", found, 0);

        // Random searches with occasional winners and aborts
        for (int it = 0; it < 8; it++) begin
            int ab;
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 12)) : -1;
            run_search({$urandom, $urandom}, $urandom_range(1, 20),
                       {4'h0, $urandom, 28'($urandom)}, ab, 1,
                       1, $urandom_range(1, 8), $urandom_range(50, 100), 0, -1);
        end

`ifdef PROGPOW_SEARCH_RSPCHK_EN
        run_search(64'd100, 6, 64'd0, -1, 0, 1, 3, 100, 0, 2);
`endif

        // Reset mid-search; late responses must be ignored
        setup_search(64'h1234, 8, 64'd0, -1, 0, 15, 20, 100, 0, -1);
        repeat (6) tick();
        start_en = 1'b0;
        rst_drv  = 1'b1;
        repeat (2) tick();
        rst_drv  = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_hashes", hashes_done, 0);
        chk("mid_rst_req_valid", req_valid, 0);
        repeat (30) tick();
        chk("post_rst_hashes", hashes_done, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_found", found, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
